// File: rtl/sti_dac_pkg.sv
// sti_dac_pkg: shared state encoding, frame-length codes and the frame-length
// helper used by the sti_dac_gen2 serial transmitter.
package sti_dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAD   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // pi_length codes: frame length as a multiple of the data width.
  localparam logic [1:0] LEN_HALF     = 2'b00;
  localparam logic [1:0] LEN_FULL     = 2'b01;
  localparam logic [1:0] LEN_ONE_HALF = 2'b10;
  localparam logic [1:0] LEN_DOUBLE   = 2'b11;

  // Number of serial bits in a frame for a given data width and length code.
  function automatic int unsigned frame_len(input int unsigned data_w,
                                            input logic [1:0]  len_code);
    int unsigned len;
    case (len_code)
      LEN_HALF:     len = data_w / 2;
      LEN_FULL:     len = data_w;
      LEN_ONE_HALF: len = (3 * data_w) / 2;
      default:      len = 2 * data_w;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/sti_pixel_packer.sv
// sti_pixel_packer: collects the serial stream into PIX_W-bit pixels and
// issues one write strobe per pixel at an auto-incrementing address. A pad
// request writes a zero pixel at the next address instead.
module sti_pixel_packer #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              pad_req,
  output logic              pixel_wr,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [PIX_W-1:0]  pixel_dataout
);

  localparam int CNT_W = (PIX_W > 1) ? $clog2(PIX_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIX_W - 1);

  logic [PIX_W-1:0]  pix_q, pix_d, pix_shift;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [PIX_W-1:0]  dout_q, dout_d;

  // Next-state logic: shift in at the LSB, launch a write on every full pixel or pad request.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    pix_d     = pix_q;
    bit_cnt_d = bit_cnt_q;
    addr_d    = wr_q ? addr_q + ADDR_W'(1) : addr_q;
    wr_d      = 1'b0;
    dout_d    = dout_q;
    pix_shift = (pix_q << 1) | PIX_W'(bit_in);

    if (bit_valid) begin
      pix_d = pix_shift;
      if (bit_cnt_q == CNT_LAST) begin
        bit_cnt_d = '0;
        wr_d      = 1'b1;
        dout_d    = pix_shift;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end else if (pad_req) begin
      wr_d   = 1'b1;
      dout_d = '0;
    end
  end

  // Packer registers; reset discards any partially assembled pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_q     <= '0;
      bit_cnt_q <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      dout_q    <= '0;
    end else begin
      pix_q     <= pix_d;
      bit_cnt_q <= bit_cnt_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      dout_q    <= dout_d;
    end
  end

  assign pixel_wr      = wr_q;
  assign pixel_addr    = addr_q;
  assign pixel_dataout = dout_q;

endmodule

// File: rtl/sti_dac_gen2.sv
// sti_dac_gen2: serial transmitter and pixel-memory arranger. Builds a frame
// from each loaded word, shifts it out one bit per cycle and packs the same
// stream into pixel writes. Define STI_DAC_ZERO_PAD_EN to zero-fill the rest
// of pixel memory after the final word before raising pixel_finish.
module sti_dac_gen2
  import sti_dac_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = 8,
  parameter int NUM_PIX = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] pi_data,
  input  logic [1:0]        pi_length,
  input  logic              pi_fill,
  input  logic              pi_msb,
  input  logic              pi_low,
  input  logic              pi_end,
  output logic              busy,
  output logic              so_data,
  output logic              so_valid,
  output logic              pixel_wr,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [PIX_W-1:0]  pixel_dataout,
  output logic              pixel_finish
);

  localparam int HALF_W  = DATA_W / 2;
  localparam int FRAME_W = 2 * DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

`ifdef STI_DAC_ZERO_PAD_EN
  localparam state_e            END_STATE = ST_PAD;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);
`else
  localparam state_e            END_STATE = ST_DONE;
`endif

  // Frames always end on a pixel boundary only if half a word is whole pixels.
  if (NUM_PIX > (1 << ADDR_W) || (DATA_W % (2 * PIX_W)) != 0) begin : g_bad_params
    $error("sti_dac_gen2: illegal DATA_W/PIX_W/ADDR_W/NUM_PIX combination");
  end

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic               msb_q, msb_d;
  logic               end_q, end_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] frame_raw, frame_aligned;
  logic               tx_bit;
  logic               pad_req;

  // Frame construction from live inputs, aligned so the first bit sent sits at the shift end.
  always_comb begin
    frame_raw = '0;
    case (pi_length)
      LEN_HALF: frame_raw[HALF_W-1:0] = pi_low ? pi_data[DATA_W-1:HALF_W]
                                               : pi_data[HALF_W-1:0];
      LEN_FULL: frame_raw[DATA_W-1:0] = pi_data;
      LEN_ONE_HALF: begin
        if (pi_fill) frame_raw[3*HALF_W-1:HALF_W] = pi_data;
        else         frame_raw[DATA_W-1:0]        = pi_data;
      end
      default: begin
        if (pi_fill) frame_raw[FRAME_W-1:DATA_W] = pi_data;
        else         frame_raw[DATA_W-1:0]       = pi_data;
      end
    endcase
    frame_aligned = pi_msb ? frame_raw << (FRAME_W - int'(frame_len(DATA_W, pi_length)))
                           : frame_raw;
  end

  assign tx_bit = msb_q ? sh_q[FRAME_W-1] : sh_q[0];

  // FSM next state, frame capture/shift and pad-write requests.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    msb_d   = msb_q;
    end_d   = end_q;
    cnt_d   = cnt_q;
    pad_req = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          sh_d    = frame_aligned;
          msb_d   = pi_msb;
          end_d   = pi_end;
          cnt_d   = CNT_W'(frame_len(DATA_W, pi_length));
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sh_d  = msb_q ? sh_q << 1 : sh_q >> 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = end_q ? END_STATE : ST_IDLE;
        end
      end
`ifdef STI_DAC_ZERO_PAD_EN
      ST_PAD: begin
        // Stop once the write to the last memory location is on the bus.
        if (pixel_wr && pixel_addr == LAST_ADDR) begin
          state_d = ST_DONE;
        end else begin
          pad_req = 1'b1;
        end
      end
`endif
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and frame registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments and clears asynchronously on reset low.
    if (!reset) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      msb_q   <= 1'b0;
      end_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      msb_q   <= msb_d;
      end_q   <= end_d;
      cnt_q   <= cnt_d;
    end
  end

  assign so_valid = (state_q == ST_SHIFT);
  assign so_data  = so_valid & tx_bit;
  assign busy     = (state_q == ST_SHIFT) || (state_q == ST_PAD);

  // The final data write can share the first DONE cycle; finish waits until it has left the bus.
  assign pixel_finish = (state_q == ST_DONE) && !pixel_wr;

  sti_pixel_packer #(
    .PIX_W (PIX_W),
    .ADDR_W(ADDR_W)
  ) u_packer (
    .clk          (clk),
    .reset        (reset),
    .bit_valid    (so_valid),
    .bit_in       (so_data),
    .pad_req      (pad_req),
    .pixel_wr     (pixel_wr),
    .pixel_addr   (pixel_addr),
    .pixel_dataout(pixel_dataout)
  );

endmodule

// File: tb/tb_sti_dac_gen2.sv
// tb_sti_dac_gen2: table-driven and randomized self-checking bench for
// sti_dac_gen2 with a bit-list reference model of the frame and packer.
module tb_sti_dac_gen2;

  localparam int DATA_W  = 16;
  localparam int PIX_W   = 8;
  localparam int ADDR_W  = 8;
  localparam int NUM_PIX = 256;
  localparam int HALF_W  = DATA_W / 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              load;
  logic [DATA_W-1:0] pi_data;
  logic [1:0]        pi_length;
  logic              pi_fill, pi_msb, pi_low, pi_end;
  logic              busy, so_data, so_valid, pixel_wr, pixel_finish;
  logic [ADDR_W-1:0] pixel_addr;
  logic [PIX_W-1:0]  pixel_dataout;

  always #5 clk = ~clk;

  sti_dac_gen2 #(
    .DATA_W(DATA_W), .PIX_W(PIX_W), .ADDR_W(ADDR_W), .NUM_PIX(NUM_PIX)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .pi_data(pi_data),
    .pi_length(pi_length), .pi_fill(pi_fill), .pi_msb(pi_msb),
    .pi_low(pi_low), .pi_end(pi_end), .busy(busy), .so_data(so_data),
    .so_valid(so_valid), .pixel_wr(pixel_wr), .pixel_addr(pixel_addr),
    .pixel_dataout(pixel_dataout), .pixel_finish(pixel_finish)
  );

  typedef struct {
    int addr;
    int data;
  } wr_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [1:0]        len;
    bit                fill;
    bit                msb;
    bit                low;
    logic [31:0]       pix;   // expected pixels, first pixel most significant
  } vec_t;

  int  n_checks = 0;
  int  n_errors = 0;
  int  exp_addr = 0;
  int  bad_idle_data = 0;
  bit  got_bits[$];
  wr_t got_wr[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One cycle: wait for the falling edge and record serial bits and pixel writes.
  task automatic tick();
    wr_t w;
    @(negedge clk);
    if (so_valid) got_bits.push_back(so_data);
    else if (so_data !== 1'b0) bad_idle_data++;
    if (pixel_wr) begin
      w.addr = int'(pixel_addr);
      w.data = int'(pixel_dataout);
      got_wr.push_back(w);
    end
  endtask

  function automatic int model_len(input logic [1:0] len);
    return (int'(len) + 1) * HALF_W;
  endfunction

  // Frame value with bit 0 = frame LSB, built from the length/fill/half rules.
  function automatic logic [63:0] model_frame(input logic [DATA_W-1:0] data, input logic [1:0] len,
                                              input bit fill, input bit low);
    logic [63:0] d;
    d = 64'(data);
    case (len)
      2'b00:   return low ? (d >> HALF_W) : (d % (64'd1 << HALF_W));
      2'b01:   return d;
      default: return fill ? (d << (model_len(len) - DATA_W)) : d;
    endcase
  endfunction

  task automatic do_reset();
    load  = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    exp_addr = 0;
  endtask

  // Load one word right after a tick, follow it to its last pixel write, and compare.
  task automatic run_frame(input logic [DATA_W-1:0] data, input logic [1:0] len,
                           input bit fill, input bit msb, input bit low,
                           input bit endf, input bit noise, output logic [63:0] pix_out);
    int          L, npix, exp_pix, cyc, exp_pad, bad_pad;
    logic [63:0] fr, exp_stream, got_stream;
    bit          eb[64];
    L = model_len(len);
    npix = L / PIX_W;
    fr = model_frame(data, len, fill, low);
    exp_stream = '0;
    got_stream = '0;
    pix_out = '0;
    for (int i = 0; i < L; i++) begin
      eb[i] = msb ? fr[L-1-i] : fr[i];
      exp_stream = (exp_stream << 1) | 64'(eb[i]);
    end
    got_bits.delete();
    got_wr.delete();
    bad_idle_data = 0;

    load = 1'b1; pi_data = data; pi_length = len;
    pi_fill = fill; pi_msb = msb; pi_low = low; pi_end = endf;
    for (int t = 1; t <= L; t++) begin
      tick();
      if (noise && t < L) begin
        load      = 1'($urandom_range(0, 1));
        pi_data   = DATA_W'($urandom);
        pi_length = 2'($urandom_range(0, 3));
        pi_fill   = 1'($urandom_range(0, 1));
        pi_msb    = 1'($urandom_range(0, 1));
        pi_low    = 1'($urandom_range(0, 1));
        pi_end    = 1'($urandom_range(0, 1));
      end else begin
        load   = 1'b0;
        pi_end = 1'b0;
      end
    end
    tick();
    check("final_write_strobe", pixel_wr, 1);
    check("valid_gap", so_valid, 0);
    check("finish_at_last_write", pixel_finish, 0);

    foreach (got_bits[i]) got_stream = (got_stream << 1) | 64'(got_bits[i]);
    check("bit_count", got_bits.size(), L);
    check("stream", got_stream, exp_stream);
    check("idle_so_data", bad_idle_data, 0);
    check("write_count", got_wr.size(), npix);
    for (int k = 0; k < npix; k++) begin
      exp_pix = 0;
      for (int b = 0; b < PIX_W; b++) exp_pix = (exp_pix << 1) | int'(eb[k*PIX_W + b]);
      if (k < got_wr.size()) begin
        check("pix_addr", got_wr[k].addr, exp_addr % (1 << ADDR_W));
        check("pix_data", got_wr[k].data, exp_pix);
        pix_out = (pix_out << PIX_W) | 64'(got_wr[k].data);
      end
      exp_addr++;
    end

    if (endf) begin
`ifdef STI_DAC_ZERO_PAD_EN
      exp_pad = NUM_PIX - exp_addr;
      got_wr.delete();
      cyc = 0;
      while (!pixel_finish && cyc < 600) begin
        tick();
        cyc++;
      end
      check("pad_write_count", got_wr.size(), exp_pad);
      bad_pad = 0;
      foreach (got_wr[k]) if (got_wr[k].addr != exp_addr + k || got_wr[k].data != 0) bad_pad++;
      check("pad_writes_bad", bad_pad, 0);
      check("finish_latency", cyc, exp_pad + 1);
      exp_addr = NUM_PIX;
`else
      cyc = 0; exp_pad = 0; bad_pad = 0;
      tick();
      check("finish_after_last_write", pixel_finish, 1);
      check("no_write_after_end", pixel_wr, 0);
`endif
      check("finish_flag", pixel_finish, 1);
      check("busy_done", busy, 0);
    end
  endtask

  initial begin
    vec_t        tbl[7];
    logic [63:0] px;

    tbl[0] = '{16'hA53C, 2'b00, 1'b0, 1'b1, 1'b1, 32'h000000A5};
    tbl[1] = '{16'h1234, 2'b11, 1'b0, 1'b1, 1'b0, 32'h00001234};
    tbl[2] = '{16'h8001, 2'b10, 1'b1, 1'b0, 1'b0, 32'h00008001};
    tbl[3] = '{16'h1234, 2'b01, 1'b0, 1'b1, 1'b0, 32'h00001234};
    tbl[4] = '{16'h1234, 2'b01, 1'b0, 1'b0, 1'b0, 32'h00002C48};
    tbl[5] = '{16'hA53C, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0000003C};
    tbl[6] = '{16'h1200, 2'b00, 1'b0, 1'b0, 1'b1, 32'h00000048};

    reset = 1'b1; load = 1'b0; pi_data = '0; pi_length = '0;
    pi_fill = 1'b0; pi_msb = 1'b0; pi_low = 1'b0; pi_end = 1'b0;
    #1 reset = 1'b0;
    repeat (3) tick();
    check("rst_so_valid", so_valid, 0);
    check("rst_so_data", so_data, 0);
    check("rst_pixel_wr", pixel_wr, 0);
    check("rst_pixel_addr", pixel_addr, 0);
    check("rst_pixel_dataout", pixel_dataout, 0);
    check("rst_finish", pixel_finish, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    repeat (2) tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", so_valid, 0);

    // Directed frames, back to back, with mid-frame input noise on odd entries.
    foreach (tbl[i]) begin
      run_frame(tbl[i].data, tbl[i].len, tbl[i].fill, tbl[i].msb, tbl[i].low,
                1'b0, bit'(i % 2), px);
      check("tbl_pixels", px, 64'(tbl[i].pix));
    end

    // Reset in the middle of a frame while a pixel write is on the bus.
    load = 1'b1; pi_data = 16'hBEEF; pi_length = 2'b11; pi_end = 1'b0;
    repeat (9) begin
      tick();
      load = 1'b0;
    end
    check("pre_reset_write", pixel_wr, 1);
    check("pre_reset_valid", so_valid, 1);
    reset = 1'b0;
    #1;
    check("mid_reset_so_valid", so_valid, 0);
    check("mid_reset_pixel_wr", pixel_wr, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_addr", pixel_addr, 0);
    tick();
    reset = 1'b1;
    tick();
    exp_addr = 0;
    run_frame(16'hA53C, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, px);
    check("after_reset_pixels", px, 64'hA5);

    // Randomized frames against the model.
    for (int n = 0; n < 30; n++) begin
      run_frame(DATA_W'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                1'($urandom_range(0, 1)), px);
      if ($urandom_range(0, 3) == 0) tick();
    end

    // Final word after a fresh start: four data pixels, then pad or finish.
    do_reset();
    run_frame(16'h1234, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, px);
    check("end_frame_pixels", px, 64'h00001234);

    // Loads in DONE are ignored until reset.
    got_bits.delete();
    got_wr.delete();
    load = 1'b1; pi_data = 16'hFFFF; pi_length = 2'b01;
    tick();
    load = 1'b0;
    repeat (4) tick();
    check("done_no_bits", got_bits.size(), 0);
    check("done_no_writes", got_wr.size(), 0);
    check("done_busy", busy, 0);
    check("done_finish_held", pixel_finish, 1);

`ifdef STI_DAC_ZERO_PAD_EN
    // Fill memory exactly with data so the pad phase has nothing to write.
    do_reset();
    for (int n = 0; n < NUM_PIX / 4 - 1; n++) begin
      run_frame(DATA_W'($urandom), 2'b11, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, px);
    end
    run_frame(16'h5AC3, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, px);
    check("full_mem_last_pixels", px, 64'h5AC30000);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
